// File: rtl/cacheline_adaptor.sv
// Cache line <-> memory burst adaptor.
// Splits 256-bit writebacks into 64-bit bursts and assembles fills.
module cacheline_adaptor #(
   parameter int S_LINE   = 256,
   parameter int S_BURST  = 64,
   parameter int S_OFFSET = 5
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [S_LINE-1:0]   line_i,
   output logic [S_LINE-1:0]   line_o,
   input  logic [31:0]         address_i,
   input  logic                read_i,
   input  logic                write_i,
   output logic                resp_o,
   input  logic [S_BURST-1:0]  burst_i,
   output logic [S_BURST-1:0]  burst_o,
   output logic [31:0]         address_o,
   output logic                read_o,
   output logic                write_o,
   input  logic                resp_i
);

   localparam int NB = S_LINE / S_BURST;
   localparam int CW = (NB > 1) ? $clog2(NB) : 1;
   localparam int BW = $clog2(S_BURST);
   localparam logic [31:0] OFF_MASK = (32'h1 << S_OFFSET) - 32'h1;
   localparam logic [CW-1:0] LAST = CW'(NB - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WRITE = 2'd1,
      READ  = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t              state_q;
   logic [CW-1:0]       count_q;
   logic [CW-1:0]       count_d;
   logic [S_LINE-1:0]   buf_q;
   logic [S_LINE-1:0]   fill_d;
   logic [S_LINE-1:0]   line_q;
   logic [S_BURST-1:0]  burst_q;
   logic [S_BURST-1:0]  next_slice_d;
   logic [31:0]         address_q;
   logic                read_q;
   logic                write_q;
   logic                resp_q;
   logic                last_d;

   // Burst index bookkeeping for the current and next slice.
   always_comb begin
      count_d = count_q + 1'b1;
      last_d = (count_q == LAST);
      next_slice_d = buf_q[{count_d, {BW{1'b0}}} +: S_BURST];
   end

   // Buffer image with the incoming read burst merged into its slot.
   always_comb begin
      fill_d = buf_q;
      fill_d[{count_q, {BW{1'b0}}} +: S_BURST] = burst_i;
   end

   // Main control FSM; all outputs are registered.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= IDLE;
         count_q   <= '0;
         buf_q     <= '0;
         line_q    <= '0;
         burst_q   <= '0;
         address_q <= '0;
         read_q    <= 1'b0;
         write_q   <= 1'b0;
         resp_q    <= 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               resp_q <= 1'b0;
               if (write_i || read_i) begin
                  address_q <= address_i & ~OFF_MASK;
                  buf_q     <= line_i;
                  burst_q   <= line_i[S_BURST-1:0];
                  count_q   <= '0;
               end
               if (write_i) begin
                  write_q <= 1'b1;
                  state_q <= WRITE;
               end else if (read_i) begin
                  read_q  <= 1'b1;
                  state_q <= READ;
               end
            end
            WRITE: begin
               if (resp_i) begin
                  if (last_d) begin
                     count_q <= '0;
                     write_q <= 1'b0;
                     resp_q  <= 1'b1;
                     state_q <= DONE;
                  end else begin
                     count_q <= count_d;
                     burst_q <= next_slice_d;
                  end
               end
            end
            READ: begin
               if (resp_i) begin
                  buf_q <= fill_d;
                  if (last_d) begin
                     count_q <= '0;
                     read_q  <= 1'b0;
                     resp_q  <= 1'b1;
                     line_q  <= fill_d;
                     state_q <= DONE;
                  end else begin
                     count_q <= count_d;
                  end
               end
            end
            DONE: begin
               resp_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign line_o    = line_q;
   assign burst_o   = burst_q;
   assign address_o = address_q;
   assign read_o    = read_q;
   assign write_o   = write_q;
   assign resp_o    = resp_q;

endmodule
